// File: rtl/sccb_target_regs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sccb_target_regs                                                |
// | Purpose  : SCCB/I2C target emulating a camera sensor register file with    |
// |            16-bit register addressing, burst read/write and write strobes. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sccb_target_regs #(
    parameter logic [6:0] DEV_ADDR  = 7'h36,
    parameter int         REG_DEPTH = 256,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic        wr_stb,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    input  logic [15:0] sys_raddr,
    output logic [7:0]  sys_rdata
);

    localparam int          c_aw    = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam logic [16:0] c_depth = 17'(REG_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DEVADDR = 3'd1,
        S_REGH    = 3'd2,
        S_REGL    = 3'd3,
        S_WDATA   = 3'd4,
        S_RDATA   = 3'd5,
        S_WAIT    = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [2:0]  r_scl_sync;
    logic [2:0]  r_sda_sync;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_shift;
    logic [6:0]  r_tx;
    logic [15:0] r_ptr;
    logic        r_pend;
    logic        r_ack_slot;
    logic        r_do_ack;
    logic        r_rd_first;
    logic        r_mack;
    logic [7:0]  r_regs [0:REG_DEPTH-1];

    logic        w_scl;
    logic        w_scl_d;
    logic        w_sda;
    logic        w_sda_d;
    logic        w_start;
    logic        w_stop;
    logic        w_rise;
    logic        w_fall;
    logic        w_byte_done;
    logic [7:0]  w_byte;
    logic        w_addr_match;
    logic        w_ptr_in_range;
    logic [7:0]  w_rd_byte;

    // Bit [1] is the synchronized level, bit [2] the previous one for edges.
    // Reset to the idle-bus level so no spurious edge is seen after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_sync <= 3'b111;
            r_sda_sync <= 3'b111;
        end else begin
            r_scl_sync <= {r_scl_sync[1:0], scl_i};
            r_sda_sync <= {r_sda_sync[1:0], sda_i};
        end
    end

    assign w_scl   = r_scl_sync[1];
    assign w_scl_d = r_scl_sync[2];
    assign w_sda   = r_sda_sync[1];
    assign w_sda_d = r_sda_sync[2];

    assign w_start = w_scl & w_scl_d &  w_sda_d & ~w_sda;
    assign w_stop  = w_scl & w_scl_d & ~w_sda_d &  w_sda;
    assign w_rise  =  w_scl & ~w_scl_d;
    assign w_fall  = ~w_scl &  w_scl_d;

    assign w_byte_done    = w_rise & ~r_ack_slot & (r_bit_cnt == 3'd7);
    assign w_byte         = {r_shift, w_sda};
    assign w_addr_match   = (w_byte[7:1] == DEV_ADDR);
    assign w_ptr_in_range = ({1'b0, r_ptr} < c_depth);
    assign w_rd_byte      = w_ptr_in_range ? r_regs[r_ptr[c_aw-1:0]] : 8'h00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_start) begin
            w_state_nxt = S_DEVADDR;
        end else if (w_byte_done) begin
            case (r_state)
                S_DEVADDR: begin
                    if (!w_addr_match) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_byte[0]) begin
                        w_state_nxt = S_RDATA;
                    end else begin
                        w_state_nxt = S_REGH;
                    end
                end
                S_REGH:  w_state_nxt = S_REGL;
                S_REGL:  w_state_nxt = S_WDATA;
                default: w_state_nxt = r_state;
            endcase
        end else if (w_fall && r_ack_slot && (r_state == S_RDATA) &&
                     !r_rd_first && !r_mack) begin
            w_state_nxt = S_WAIT;
        end
    end

    // Bit engine, pointer, register file and bus-side outputs.
    // r_pend marks "byte complete, ACK slot starts at the next SCL fall".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sda_oe     <= 1'b0;
            wr_stb     <= 1'b0;
            wr_addr    <= 16'h0000;
            wr_data    <= 8'h00;
            busy       <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 7'h00;
            r_tx       <= 7'h00;
            r_ptr      <= 16'h0000;
            r_pend     <= 1'b0;
            r_ack_slot <= 1'b0;
            r_do_ack   <= 1'b0;
            r_rd_first <= 1'b0;
            r_mack     <= 1'b0;
            for (int i = 0; i < REG_DEPTH; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else begin
            wr_stb <= 1'b0;
            if (w_stop) begin
                sda_oe     <= 1'b0;
                busy       <= 1'b0;
                r_bit_cnt  <= 3'd0;
                r_pend     <= 1'b0;
                r_ack_slot <= 1'b0;
                r_do_ack   <= 1'b0;
                r_rd_first <= 1'b0;
            end else if (w_start) begin
                sda_oe     <= 1'b0;
                r_bit_cnt  <= 3'd0;
                r_pend     <= 1'b0;
                r_ack_slot <= 1'b0;
                r_do_ack   <= 1'b0;
                r_rd_first <= 1'b0;
            end else begin
                if (w_rise && !r_ack_slot) begin
                    r_shift   <= w_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end

                if (w_byte_done) begin
                    r_pend   <= 1'b1;
                    r_do_ack <= 1'b0;
                    case (r_state)
                        S_DEVADDR: begin
                            if (w_addr_match) begin
                                r_do_ack   <= 1'b1;
                                busy       <= 1'b1;
                                r_rd_first <= w_byte[0];
                            end else begin
                                busy <= 1'b0;
                            end
                        end
                        S_REGH: begin
                            r_ptr[15:8] <= w_byte;
                            r_do_ack    <= 1'b1;
                        end
                        S_REGL: begin
                            r_ptr[7:0] <= w_byte;
                            r_do_ack   <= 1'b1;
                        end
                        S_WDATA: begin
                            r_do_ack <= 1'b1;
                            wr_stb   <= 1'b1;
                            wr_addr  <= r_ptr;
                            wr_data  <= w_byte;
                            if (w_ptr_in_range) begin
                                r_regs[r_ptr[c_aw-1:0]] <= w_byte;
                            end
                            r_ptr <= r_ptr + 16'd1;
                        end
                        default: ;
                    endcase
                end

                // Master ACK/NACK after a transmitted byte; advance on ACK so the
                // next byte is fetched from the new pointer at the following fall.
                if (w_rise && r_ack_slot && (r_state == S_RDATA) && !r_rd_first) begin
                    r_mack <= ~w_sda;
                    if (!w_sda) begin
                        r_ptr <= r_ptr + 16'd1;
                    end
                end

                if (w_fall) begin
                    if (r_pend) begin
                        r_pend     <= 1'b0;
                        r_ack_slot <= 1'b1;
                        sda_oe     <= r_do_ack;
                    end else if (r_ack_slot) begin
                        r_ack_slot <= 1'b0;
                        sda_oe     <= 1'b0;
                        if ((r_state == S_RDATA) && (r_rd_first || r_mack)) begin
                            r_rd_first <= 1'b0;
                            r_tx       <= w_rd_byte[6:0];
                            sda_oe     <= ~w_rd_byte[7];
                        end
                    end else if (r_state == S_RDATA) begin
                        r_tx   <= {r_tx[5:0], 1'b0};
                        sda_oe <= ~r_tx[6];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sys_rdata <= 8'h00;
        end else if ({1'b0, sys_raddr} < c_depth) begin
            sys_rdata <= r_regs[sys_raddr[c_aw-1:0]];
        end else begin
            sys_rdata <= 8'h00;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sccb_target_regs.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_sccb_target_regs                                             |
// | Purpose  : Bus-level bench acting as SCCB master against sccb_target_regs.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sccb_target_regs;

    localparam int c_q = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        scl;
    logic        sda_m;
    logic        sda_line;
    logic        sda_oe;
    logic        wr_stb;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic [15:0] sys_raddr;
    logic [7:0]  sys_rdata;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] rd_q[$];
    wr_t        exp_wr;
    int         n_tests = 0;
    int         n_fail  = 0;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    sccb_target_regs #(
        .DEV_ADDR  (7'h36),
        .REG_DEPTH (256),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .sys_raddr (sys_raddr),
        .sys_rdata (sys_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write-strobe scoreboard: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (wr_stb) begin
            if (wr_q.size() == 0) begin
                check("wr_stb_unexpected", {31'd0, wr_stb}, 32'd0);
            end else begin
                exp_wr = wr_q.pop_front();
                check("wr_addr", {16'd0, wr_addr}, {16'd0, exp_wr.addr});
                check("wr_data", {24'd0, wr_data}, {24'd0, exp_wr.data});
            end
        end
    end

    task automatic bus_start();
        sda_m = 1'b1; #(c_q);
        scl   = 1'b1; #(c_q);
        sda_m = 1'b0; #(c_q);
        scl   = 1'b0; #(c_q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #(c_q);
        scl   = 1'b1; #(c_q);
        sda_m = 1'b1; #(2*c_q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; #(c_q);
        scl   = 1'b1; #(2*c_q);
        scl   = 1'b0; #(c_q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; #(c_q);
        scl   = 1'b1; #(c_q);
        ack   = ~sda_line; #(c_q);
        scl   = 1'b0; #(c_q);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        sda_m = 1'b1;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            #(c_q); scl = 1'b1;
            #(c_q); b = {b[6:0], sda_line};
            #(c_q); scl = 1'b0;
            #(c_q);
        end
        sda_m = ~mack; #(c_q);
        scl   = 1'b1; #(2*c_q);
        scl   = 1'b0; #(c_q);
        sda_m = 1'b1;
    endtask

    task automatic send_acked(input string tag, input logic [7:0] b);
        logic ack;
        write_byte(b, ack);
        check(tag, {31'd0, ack}, 32'd1);
    endtask

    task automatic write_header(input logic [15:0] a);
        bus_start();
        send_acked("ack_dev_w", 8'h6C);
        check("busy_addressed", {31'd0, busy}, 32'd1);
        send_acked("ack_regh", a[15:8]);
        send_acked("ack_regl", a[7:0]);
    endtask

    task automatic write_data(input logic [15:0] a, input logic [7:0] d);
        wr_q.push_back('{addr: a, data: d});
        send_acked("ack_wdata", d);
    endtask

    task automatic read_check(input logic mack);
        logic [7:0] got;
        logic [7:0] exp;
        read_byte(mack, got);
        exp = rd_q.pop_front();
        check("rd_byte", {24'd0, got}, {24'd0, exp});
    endtask

    task automatic peek(input logic [15:0] a, input logic [7:0] exp);
        @(negedge clk) sys_raddr = a;
        @(posedge clk);
        @(negedge clk);
        check("peek", {24'd0, sys_rdata}, {24'd0, exp});
    endtask

    initial begin
        logic ack;
        reset     = 1'b1;
        scl       = 1'b1;
        sda_m     = 1'b1;
        sys_raddr = 16'h0000;
        #23;
        check("rst_sda_oe",  {31'd0, sda_oe},  32'd0);
        check("rst_wr_stb",  {31'd0, wr_stb},  32'd0);
        check("rst_busy",    {31'd0, busy},    32'd0);
        check("rst_wr_addr", {16'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        check("rst_rdata",   {24'd0, sys_rdata}, 32'd0);
        #20 reset = 1'b0;
        #(2*c_q);

        // Single write to an in-range register.
        write_header(16'h0010);
        write_data(16'h0010, 8'h01);
        bus_stop();
        check("busy_after_stop", {31'd0, busy}, 32'd0);
        peek(16'h0010, 8'h01);

        // Burst write with auto-increment.
        write_header(16'h0020);
        write_data(16'h0020, 8'hAA);
        write_data(16'h0021, 8'hBB);
        write_data(16'h0022, 8'hCC);
        bus_stop();
        peek(16'h0020, 8'hAA);
        peek(16'h0021, 8'hBB);
        peek(16'h0022, 8'hCC);

        // Set pointer, repeated START, read two bytes (ACK then NACK).
        write_header(16'h0021);
        bus_start();
        send_acked("ack_dev_r", 8'h6D);
        rd_q.push_back(8'hBB);
        rd_q.push_back(8'hCC);
        read_check(1'b1);
        read_check(1'b0);
        #(c_q);
        check("wait_busy",   {31'd0, busy},   32'd1);
        check("wait_sda_oe", {31'd0, sda_oe}, 32'd0);
        bus_stop();
        check("busy_read_stop", {31'd0, busy}, 32'd0);

        // Foreign device address: no ACK, no busy, following bytes ignored.
        bus_start();
        write_byte(8'h78, ack);
        check("nack_foreign", {31'd0, ack}, 32'd0);
        check("busy_foreign", {31'd0, busy}, 32'd0);
        write_byte(8'h00, ack);
        check("ignored_byte", {31'd0, ack}, 32'd0);
        bus_stop();

        // Pointer wrap at 0xFFFF; out-of-range write strobed but not stored.
        write_header(16'hFFFF);
        write_data(16'hFFFF, 8'h55);
        write_data(16'h0000, 8'h66);
        bus_stop();
        peek(16'h0000, 8'h66);
        peek(16'hFFFF, 8'h00);

        // Reset during the data-byte ACK.
        write_header(16'h0030);
        wr_q.push_back('{addr: 16'h0030, data: 8'h77});
        for (int i = 7; i >= 0; i--) send_bit(8'h77 >> i);
        check("ack_driven", {31'd0, sda_oe}, 32'd1);
        #3 reset = 1'b1;
        #1;
        check("rst_async_sda", {31'd0, sda_oe}, 32'd0);
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        #50 reset = 1'b0;
        sda_m = 1'b1;
        scl   = 1'b1;
        #(2*c_q);
        peek(16'h0021, 8'h00);
        peek(16'h0030, 8'h00);
        write_header(16'h0040);
        write_data(16'h0040, 8'h99);
        bus_stop();
        peek(16'h0040, 8'h99);

        #(c_q);
        check("wr_q_drained", wr_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
